// File: rtl/scroll_ctrl.sv
// Rotation-offset controller for a scrolling message: timed auto-advance or
// debounced manual stepping. Define SCROLL_REVERSE_EN to honour dir (reverse).
module scroll_ctrl #(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MSG_LEN         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step_n,
  input  logic       dir,
  output logic [2:0] pos,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    POS_LAST = 3'(MSG_LEN - 1);

  logic [PW-1:0] presc;
  logic [DW-1:0] deb_cnt;
  logic          sync1, sync2, stable;
  logic          auto_adv, press_req, adv, go_rev;
  logic [2:0]    nxt_pos;
  logic          nxt_wrap;

`ifdef SCROLL_REVERSE_EN
  assign go_rev = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign go_rev     = 1'b0;
`endif

  assign auto_adv = run && (presc == PRE_LAST);

  // A pause always discards the partial count so a resume waits a full period.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                presc <= '0;
    else if (!run || auto_adv) presc <= '0;
    else                      presc <= presc + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= step_n;
      sync2 <= sync1;
    end
  end

  // Press is recognised on the very edge the debounced level falls.
  assign press_req = stable && !sync2 && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable  <= 1'b1;
      deb_cnt <= '0;
    end else if (sync2 == stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      stable  <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  assign adv = auto_adv || (press_req && !run);

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    nxt_pos  = pos;
    nxt_wrap = 1'b0;
    if (pos > POS_LAST) begin
      nxt_pos = 3'd0;
    end else if (go_rev) begin
      if (pos == 3'd0) begin
        nxt_pos  = POS_LAST;
        nxt_wrap = 1'b1;
      end else begin
        nxt_pos = pos - 3'd1;
      end
    end else if (pos == POS_LAST) begin
      nxt_pos  = 3'd0;
      nxt_wrap = 1'b1;
    end else begin
      nxt_pos = pos + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= 3'd0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= adv;
      wrap <= adv && nxt_wrap;
      if (adv) pos <= nxt_pos;
    end
  end

endmodule
